// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch queue.
//   SIZE          data/address width of fetch words and PCs
//   WORD_BYTES    byte stride between sequential fetch addresses
//   fetch_entry_t one queue entry: instruction word plus its PC tag
//   align_word()  clears the byte-offset bits of an address
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int SIZE       = 32;
    localparam int WORD_BYTES = 4;

    typedef struct packed {
        logic [SIZE-1:0] instr;
        logic [SIZE-1:0] pc;
    } fetch_entry_t;

    function automatic logic [SIZE-1:0] align_word(input logic [SIZE-1:0] addr);
        return addr & ~(SIZE'(WORD_BYTES - 1));
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// -----------------------------------------------------------------------------
// fetch_queue_if
// Bundles the fetch queue's ROM bus, decode handshake and redirect signals.
//   modport master : fetch_queue side (drives RomAddr and the decode outputs)
//   modport slave  : environment side (ROM, decode stage, branch unit)
// Signals:
//   Redirect/RedirectPC  branch redirect request and target
//   RomAddr/RomInstr     instruction ROM address and 1-cycle-late data
//   DecodeReady          decode accepts the head entry this cycle
//   InstrValid/InstrOut/InstrPC  head entry presented to decode
//   Count                occupied queue entries
// -----------------------------------------------------------------------------
interface fetch_queue_if
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            Redirect;
    logic [SIZE-1:0] RedirectPC;
    logic [SIZE-1:0] RomAddr;
    logic [SIZE-1:0] RomInstr;
    logic            DecodeReady;
    logic            InstrValid;
    logic [SIZE-1:0] InstrOut;
    logic [SIZE-1:0] InstrPC;
    logic [CW-1:0]   Count;

    modport master (
        input  Redirect, RedirectPC, RomInstr, DecodeReady,
        output RomAddr, InstrValid, InstrOut, InstrPC, Count
    );

    modport slave (
        output Redirect, RedirectPC, RomInstr, DecodeReady,
        input  RomAddr, InstrValid, InstrOut, InstrPC, Count
    );

endinterface

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Circular buffer of fetch entries with push, pop and flush.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   i_flush    drop all entries (pointers and count cleared)
//   i_push     write i_entry at the tail
//   i_entry    entry to write
//   i_pop      advance the head (ignored when empty)
//   o_head     head entry, zero when empty
//   o_count    occupied entries, 0..DEPTH
// The caller guarantees no push when full (credit-based issue).
// -----------------------------------------------------------------------------
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  fetch_entry_t           i_entry,
    input  logic                   i_pop,
    output fetch_entry_t           o_head,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int PW = $clog2(DEPTH);

    fetch_entry_t    r_mem [DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [PW:0]     r_count;

    logic            w_empty;
    logic            w_pop;

    assign w_empty = (r_count == '0);
    assign w_pop   = i_pop && !w_empty;

    // NOTE: storage is left unreset; validity is tracked by r_count, so stale
    // words are never visible and the array stays plain RAM.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_tail] <= i_entry;
        end
    end

    // Pointers are PW bits wide, so increments wrap mod DEPTH naturally.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            if (i_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !i_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_head  = w_empty ? '0 : r_mem[r_head];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Instruction fetch/prefetch stage between a synchronous instruction ROM
// (1-cycle read latency) and decode. Issues sequential word addresses,
// queues returned words with their PC tags and presents them to decode with
// a valid/ready handshake. A redirect flushes the queue, discards the pending
// ROM response and restarts fetching at the word-aligned target.
// Ports:
//   CLK     clock, all state on posedge
//   Reset   synchronous active-high reset, overrides redirect
//   bus     fetch_queue_if.master: ROM bus, decode handshake, redirect, Count
// Parameters:
//   DEPTH     queue entries (power of two, >= 2)
//   RESET_PC  first fetch address after reset
// Configuration macro:
//   FETCH_BYPASS_EN  when defined, a ROM word arriving at an empty queue with
//                    decode ready is forwarded combinationally (latency 1)
//                    instead of being queued (latency 2).
// -----------------------------------------------------------------------------
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [SIZE-1:0] RESET_PC = '0
) (
    input  logic          CLK,
    input  logic          Reset,
    fetch_queue_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [SIZE-1:0] r_fetch_pc;
    logic [SIZE-1:0] r_issued_pc;
    logic            r_in_flight;

    logic [CW-1:0]   w_count;
    logic [CW-1:0]   w_credit_used;
    logic            w_issue;
    logic            w_bypass;
    logic            w_push;
    logic            w_pop;
    fetch_entry_t    w_head;
    fetch_entry_t    w_rom_entry;

    // Credit: queued entries plus the outstanding ROM read must leave room,
    // so every response has a guaranteed slot. CW bits hold DEPTH+1.
    assign w_credit_used = w_count + CW'(r_in_flight);
    assign w_issue       = !Reset && !bus.Redirect && (w_credit_used < CW'(DEPTH));

    assign w_rom_entry.instr = bus.RomInstr;
    assign w_rom_entry.pc    = r_issued_pc;

`ifdef FETCH_BYPASS_EN
    assign w_bypass = !Reset && !bus.Redirect && r_in_flight
                      && bus.DecodeReady && (w_count == '0);
`else
    assign w_bypass = 1'b0;
`endif

    // A redirect discards the response arriving this cycle and blocks the pop.
    assign w_push = r_in_flight && !bus.Redirect && !w_bypass;
    assign w_pop  = (w_count != '0) && bus.DecodeReady && !bus.Redirect;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_fetch_pc  <= RESET_PC;
            r_issued_pc <= '0;
            r_in_flight <= 1'b0;
        end else if (bus.Redirect) begin
            r_fetch_pc  <= align_word(bus.RedirectPC);
            r_in_flight <= 1'b0;
        end else begin
            r_in_flight <= w_issue;
            if (w_issue) begin
                r_fetch_pc  <= r_fetch_pc + SIZE'(WORD_BYTES);
                r_issued_pc <= r_fetch_pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst     (Reset),
        .i_flush (bus.Redirect),
        .i_push  (w_push),
        .i_entry (w_rom_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    // NOTE: every output gets a default first so this block cannot infer a latch.
    always_comb begin
        bus.InstrValid = (w_count != '0);
        bus.InstrOut   = w_head.instr;
        bus.InstrPC    = w_head.pc;
        if (w_bypass) begin
            bus.InstrValid = 1'b1;
            bus.InstrOut   = bus.RomInstr;
            bus.InstrPC    = r_issued_pc;
        end
    end

    assign bus.RomAddr = r_fetch_pc;
    assign bus.Count   = w_count;

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
// Directed bench for fetch_queue: reset, sequential fetch, backpressure,
// redirect flush, redirect against a pop, address wrap, mid-run reset and
// issue-to-valid latency (1 with FETCH_BYPASS_EN, 2 without).
// The ROM is modelled as a registered lookup returning rom_f(addr).
// -----------------------------------------------------------------------------
module tb_fetch_queue;
    import fetch_pkg::*;

`ifdef FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic CLK;
    logic Reset;
    int   checks = 0;
    int   errors = 0;

    fetch_queue_if #(.DEPTH(4)) bus ();

    fetch_queue #(
        .DEPTH    (4),
        .RESET_PC ('0)
    ) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] rom_f(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Synchronous ROM: data for the address seen at an edge appears after it.
    always @(posedge CLK) bus.RomInstr <= rom_f(bus.RomAddr);

    task automatic nxt();
        @(posedge CLK);
        #2;
    endtask

    task automatic do_reset();
        Reset           = 1'b1;
        bus.Redirect    = 1'b0;
        bus.RedirectPC  = '0;
        bus.DecodeReady = 1'b0;
        nxt();
        nxt();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        Reset           = 1'b1;
        bus.Redirect    = 1'b0;
        bus.RedirectPC  = '0;
        bus.DecodeReady = 1'b0;
        nxt();
        nxt();
        #1;
        checks++;
        if (bus.InstrValid !== 1'b0 || bus.Count !== 3'd0 || bus.RomAddr !== 32'h0 ||
            bus.InstrOut !== 32'h0 || bus.InstrPC !== 32'h0) begin
            errors++;
            $display("FAIL reset_state valid=%b count=%0d addr=%h out=%h pc=%h want 0 0 0 0 0",
                     bus.InstrValid, bus.Count, bus.RomAddr, bus.InstrOut, bus.InstrPC);
        end
        Reset = 1'b0;
    endtask

    task automatic test_sequential();
        logic        exp_v;
        logic [31:0] exp_pc;
        logic [2:0]  exp_cnt;
        do_reset();
        bus.DecodeReady = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_v   = (k >= LAT);
            exp_pc  = 32'(4 * (k - LAT));
            exp_cnt = (LAT == 2 && k >= 2) ? 3'd1 : 3'd0;
            checks++;
            if (bus.RomAddr !== 32'(4 * k) || bus.InstrValid !== exp_v || bus.Count !== exp_cnt) begin
                errors++;
                $display("FAIL seq_cycle%0d addr=%h valid=%b count=%0d want addr=%h valid=%b count=%0d",
                         k, bus.RomAddr, bus.InstrValid, bus.Count, 32'(4 * k), exp_v, exp_cnt);
            end
            if (exp_v) begin
                checks++;
                if (bus.InstrPC !== exp_pc || bus.InstrOut !== rom_f(exp_pc)) begin
                    errors++;
                    $display("FAIL seq_data%0d pc=%h instr=%h want pc=%h instr=%h",
                             k, bus.InstrPC, bus.InstrOut, exp_pc, rom_f(exp_pc));
                end
            end
            nxt();
        end
    endtask

    task automatic test_backpressure();
        logic [2:0]  exp_cnt [10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4};
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;
        int          got;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            #1;
            exp_addr = (k < 4) ? 32'(4 * k) : 32'h10;
            checks++;
            if (bus.Count !== exp_cnt[k] || bus.RomAddr !== exp_addr) begin
                errors++;
                $display("FAIL bp_cycle%0d count=%0d addr=%h want count=%0d addr=%h",
                         k, bus.Count, bus.RomAddr, exp_cnt[k], exp_addr);
            end
            nxt();
        end
        bus.DecodeReady = 1'b1;
        exp_pc = 32'h0;
        got    = 0;
        for (int c = 0; c < 30 && got < 8; c++) begin
            #1;
            if (bus.InstrValid) begin
                checks++;
                if (bus.InstrPC !== exp_pc || bus.InstrOut !== rom_f(exp_pc)) begin
                    errors++;
                    $display("FAIL bp_stream pc=%h instr=%h want pc=%h instr=%h",
                             bus.InstrPC, bus.InstrOut, exp_pc, rom_f(exp_pc));
                end
                exp_pc += 32'd4;
                got++;
            end
            nxt();
        end
        checks++;
        if (got != 8) begin
            errors++;
            $display("FAIL bp_stream_timeout delivered=%0d want 8", got);
        end
    endtask

    task automatic test_redirect_flush();
        logic [31:0] exp_pc;
        int          got;
        do_reset();
        for (int k = 0; k < 4; k++) nxt();
        #1;
        checks++;
        if (bus.Count !== 3'd3) begin
            errors++;
            $display("FAIL redir_precount count=%0d want 3", bus.Count);
        end
        bus.Redirect   = 1'b1;
        bus.RedirectPC = 32'h40;
        nxt();
        bus.Redirect    = 1'b0;
        bus.DecodeReady = 1'b1;
        #1;
        checks++;
        if (bus.Count !== 3'd0 || bus.InstrValid !== 1'b0 || bus.RomAddr !== 32'h40) begin
            errors++;
            $display("FAIL redir_flush count=%0d valid=%b addr=%h want 0 0 00000040",
                     bus.Count, bus.InstrValid, bus.RomAddr);
        end
        exp_pc = 32'h40;
        got    = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            #1;
            if (bus.InstrValid) begin
                checks++;
                if (bus.InstrPC !== exp_pc || bus.InstrOut !== rom_f(exp_pc)) begin
                    errors++;
                    $display("FAIL redir_stream pc=%h instr=%h want pc=%h instr=%h",
                             bus.InstrPC, bus.InstrOut, exp_pc, rom_f(exp_pc));
                end
                exp_pc += 32'd4;
                got++;
            end
            nxt();
        end
        checks++;
        if (got != 4) begin
            errors++;
            $display("FAIL redir_stream_timeout delivered=%0d want 4", got);
        end
    endtask

    task automatic test_redirect_pop();
        logic [31:0] exp_pc;
        int          got;
        do_reset();
        for (int k = 0; k < 6; k++) nxt();
        #1;
        checks++;
        if (bus.InstrValid !== 1'b1 || bus.Count !== 3'd4) begin
            errors++;
            $display("FAIL rpop_pre valid=%b count=%0d want 1 4", bus.InstrValid, bus.Count);
        end
        bus.DecodeReady = 1'b1;
        bus.Redirect    = 1'b1;
        bus.RedirectPC  = 32'h100;
        nxt();
        bus.Redirect = 1'b0;
        #1;
        checks++;
        if (bus.Count !== 3'd0 || bus.InstrValid !== 1'b0) begin
            errors++;
            $display("FAIL rpop_flush count=%0d valid=%b want 0 0", bus.Count, bus.InstrValid);
        end
        exp_pc = 32'h100;
        got    = 0;
        for (int c = 0; c < 20 && got < 3; c++) begin
            #1;
            if (bus.InstrValid) begin
                checks++;
                if (bus.InstrPC !== exp_pc || bus.InstrOut !== rom_f(exp_pc)) begin
                    errors++;
                    $display("FAIL rpop_stream pc=%h instr=%h want pc=%h instr=%h",
                             bus.InstrPC, bus.InstrOut, exp_pc, rom_f(exp_pc));
                end
                exp_pc += 32'd4;
                got++;
            end
            nxt();
        end
        checks++;
        if (got != 3) begin
            errors++;
            $display("FAIL rpop_stream_timeout delivered=%0d want 3", got);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc;
        int          got;
        do_reset();
        bus.DecodeReady = 1'b1;
        nxt();
        nxt();
        bus.Redirect   = 1'b1;
        bus.RedirectPC = 32'hFFFF_FFFE;
        nxt();
        bus.Redirect = 1'b0;
        #1;
        checks++;
        if (bus.RomAddr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_addr0 addr=%h want fffffffc", bus.RomAddr);
        end
        nxt();
        #1;
        checks++;
        if (bus.RomAddr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_addr1 addr=%h want 00000000", bus.RomAddr);
        end
        exp_pc = 32'hFFFF_FFFC;
        got    = 0;
        for (int c = 0; c < 20 && got < 3; c++) begin
            #1;
            if (bus.InstrValid) begin
                checks++;
                if (bus.InstrPC !== exp_pc || bus.InstrOut !== rom_f(exp_pc)) begin
                    errors++;
                    $display("FAIL wrap_stream pc=%h instr=%h want pc=%h instr=%h",
                             bus.InstrPC, bus.InstrOut, exp_pc, rom_f(exp_pc));
                end
                exp_pc += 32'd4;
                got++;
            end
            nxt();
        end
        checks++;
        if (got != 3) begin
            errors++;
            $display("FAIL wrap_stream_timeout delivered=%0d want 3", got);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp_pc;
        int          got;
        do_reset();
        for (int k = 0; k < 6; k++) nxt();
        Reset          = 1'b1;
        bus.Redirect   = 1'b1;
        bus.RedirectPC = 32'h300;
        nxt();
        Reset           = 1'b0;
        bus.Redirect    = 1'b0;
        bus.DecodeReady = 1'b1;
        #1;
        checks++;
        if (bus.Count !== 3'd0 || bus.InstrValid !== 1'b0 || bus.RomAddr !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_state count=%0d valid=%b addr=%h want 0 0 00000000",
                     bus.Count, bus.InstrValid, bus.RomAddr);
        end
        exp_pc = 32'h0;
        got    = 0;
        for (int c = 0; c < 20 && got < 3; c++) begin
            #1;
            if (bus.InstrValid) begin
                checks++;
                if (bus.InstrPC !== exp_pc || bus.InstrOut !== rom_f(exp_pc)) begin
                    errors++;
                    $display("FAIL rstmid_stream pc=%h instr=%h want pc=%h instr=%h",
                             bus.InstrPC, bus.InstrOut, exp_pc, rom_f(exp_pc));
                end
                exp_pc += 32'd4;
                got++;
            end
            nxt();
        end
        checks++;
        if (got != 3) begin
            errors++;
            $display("FAIL rstmid_stream_timeout delivered=%0d want 3", got);
        end
    endtask

    task automatic test_latency();
        int         first;
        logic [2:0] exp_cnt;
        do_reset();
        bus.DecodeReady = 1'b1;
        bus.Redirect    = 1'b1;
        bus.RedirectPC  = 32'h200;
        nxt();
        bus.Redirect = 1'b0;
        // Cycle 0 of the loop is the cycle the target is issued.
        first = -1;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (first < 0 && bus.InstrValid) first = k;
            exp_cnt = (LAT == 2 && k >= 2) ? 3'd1 : 3'd0;
            checks++;
            if (bus.Count !== exp_cnt) begin
                errors++;
                $display("FAIL lat_count%0d count=%0d want %0d", k, bus.Count, exp_cnt);
            end
            nxt();
        end
        checks++;
        if (first != LAT) begin
            errors++;
            $display("FAIL lat_first_valid cycle=%0d want %0d", first, LAT);
        end
    endtask

    initial begin
        bus.RomInstr = '0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_flush();
        test_redirect_pop();
        test_wrap();
        test_reset_mid();
        test_latency();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
